// File: rtl/baudgen_frac_pkg.sv
// Shared constants for the fractional baud generator: 12 MHz divisor pairs,
// minimum legal divisors and the apply-strobe encoding used inside the block.
package baudgen_frac_pkg;

    localparam int CLK_HZ        = 12_000_000;
    localparam int B115200_INT   = 104;
    localparam int B115200_FRAC  = 3;
    localparam int B9600_INT     = 1250;
    localparam int B9600_FRAC    = 0;

    // Majority voting needs mid-1 and mid+1 to exist inside the period.
    localparam int MIN_DIV_MAJ3  = 4;
    localparam int MIN_DIV_STD   = 2;

    typedef enum logic [1:0] {
        APPLY_NONE = 2'd0,
        APPLY_IDLE = 2'd1,
        APPLY_END  = 2'd2
    } apply_e;

endpackage

// File: rtl/baudgen_frac_if.sv
// Host-side configuration and bit-FSM tick bundle of the baud generator.
interface baudgen_frac_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
);
    logic              clk_ena;
    logic [DIV_W-1:0]  cfg_div_int;
    logic [FRAC_W-1:0] cfg_div_frac;
    logic              cfg_load;
    logic              cfg_pending;
    logic              cfg_clamped;
    logic              tick_pre;
    logic              tick_mid;
    logic              tick_post;
    logic              tick_end;

    modport master (
        output clk_ena, cfg_div_int, cfg_div_frac, cfg_load,
        input  cfg_pending, cfg_clamped, tick_pre, tick_mid, tick_post, tick_end
    );

    modport slave (
        input  clk_ena, cfg_div_int, cfg_div_frac, cfg_load,
        output cfg_pending, cfg_clamped, tick_pre, tick_mid, tick_post, tick_end
    );
endinterface

// File: rtl/baudgen_frac_cfg_shadow.sv
// Divisor shadow/active registers: captures host loads, clamps on apply and
// presents the divisor that governs the next period (bypassing a same-cycle apply).
module baudgen_frac_cfg_shadow
    import baudgen_frac_pkg::*;
#(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int MAJ3         = 1,
    parameter int DEF_DIV_INT  = B115200_INT,
    parameter int DEF_DIV_FRAC = B115200_FRAC
) (
    input  logic              clk,
    input  logic              rstn,
    input  apply_e            i_apply,
    input  logic              i_load,
    input  logic [DIV_W-1:0]  i_div_int,
    input  logic [FRAC_W-1:0] i_div_frac,
    output logic [DIV_W-1:0]  o_nxt_int,
    output logic [FRAC_W-1:0] o_nxt_frac,
    output logic              o_pending,
    output logic              o_clamped
);
    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'((MAJ3 != 0) ? MIN_DIV_MAJ3 : MIN_DIV_STD);

    logic [DIV_W-1:0]  r_sh_int, r_act_int;
    logic [FRAC_W-1:0] r_sh_frac, r_act_frac;
    logic              r_pending, r_clamped;

    logic              w_bypass, w_do_apply, w_clamp;
    logic [DIV_W-1:0]  w_src_int, w_app_int;
    logic [FRAC_W-1:0] w_src_frac;

    // A load landing on the boundary goes straight to the active divisor.
    assign w_bypass   = (i_apply == APPLY_END) && i_load;
    assign w_do_apply = w_bypass || ((i_apply != APPLY_NONE) && r_pending);
    assign w_src_int  = w_bypass ? i_div_int  : r_sh_int;
    assign w_src_frac = w_bypass ? i_div_frac : r_sh_frac;
    assign w_clamp    = (w_src_int < MIN_DIV);
    assign w_app_int  = w_clamp ? MIN_DIV : w_src_int;

    assign o_nxt_int  = w_do_apply ? w_app_int  : r_act_int;
    assign o_nxt_frac = w_do_apply ? w_src_frac : r_act_frac;
    assign o_pending  = r_pending;
    assign o_clamped  = r_clamped;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sh_int   <= DIV_W'(DEF_DIV_INT);
            r_sh_frac  <= FRAC_W'(DEF_DIV_FRAC);
            r_act_int  <= DIV_W'(DEF_DIV_INT);
            r_act_frac <= FRAC_W'(DEF_DIV_FRAC);
            r_pending  <= 1'b0;
            r_clamped  <= 1'b0;
        end else begin
            if (w_do_apply) begin
                r_act_int  <= w_app_int;
                r_act_frac <= w_src_frac;
                r_clamped  <= w_clamp;
            end
            if (i_load && !w_bypass) begin
                r_sh_int   <= i_div_int;
                r_sh_frac  <= i_div_frac;
                r_pending  <= 1'b1;
            end else if (w_do_apply) begin
                r_pending  <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/baudgen_frac.sv
// Fractional baud-tick generator: period counter plus phase accumulator that
// stretches a period by one cycle whenever the fractional sum overflows.
module baudgen_frac
    import baudgen_frac_pkg::*;
#(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int MAJ3         = 1,
    parameter int DEF_DIV_INT  = B115200_INT,
    parameter int DEF_DIV_FRAC = B115200_FRAC
) (
    input  logic          clk,
    input  logic          rstn,
    baudgen_frac_if.slave bus
);
    localparam logic [DIV_W:0] ONE = (DIV_W+1)'(1);

    logic [DIV_W:0]    r_cnt, r_plen;
    logic [FRAC_W-1:0] r_acc;

    logic [DIV_W-1:0]  w_nxt_int;
    logic [FRAC_W-1:0] w_nxt_frac;
    logic [FRAC_W:0]   w_sum;
    logic [DIV_W:0]    w_mid;
    logic              w_end;
    apply_e            w_apply;

    assign w_mid   = r_plen >> 1;
    assign w_end   = bus.clk_ena && (r_cnt == r_plen - ONE);
    assign w_apply = !bus.clk_ena ? APPLY_IDLE : (w_end ? APPLY_END : APPLY_NONE);
    assign w_sum   = {1'b0, r_acc} + {1'b0, w_nxt_frac};

    baudgen_frac_cfg_shadow #(
        .DIV_W        (DIV_W),
        .FRAC_W       (FRAC_W),
        .MAJ3         (MAJ3),
        .DEF_DIV_INT  (DEF_DIV_INT),
        .DEF_DIV_FRAC (DEF_DIV_FRAC)
    ) u_shadow (
        .clk        (clk),
        .rstn       (rstn),
        .i_apply    (w_apply),
        .i_load     (bus.cfg_load),
        .i_div_int  (bus.cfg_div_int),
        .i_div_frac (bus.cfg_div_frac),
        .o_nxt_int  (w_nxt_int),
        .o_nxt_frac (w_nxt_frac),
        .o_pending  (bus.cfg_pending),
        .o_clamped  (bus.cfg_clamped)
    );

    // Idle keeps the period aligned so the first enabled cycle is counter 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_plen <= (DIV_W+1)'(DEF_DIV_INT);
        end else if (!bus.clk_ena) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_plen <= {1'b0, w_nxt_int};
        end else if (w_end) begin
            r_cnt  <= '0;
            r_acc  <= w_sum[FRAC_W-1:0];
            r_plen <= {1'b0, w_nxt_int} + (DIV_W+1)'(w_sum[FRAC_W]);
        end else begin
            r_cnt  <= r_cnt + ONE;
        end
    end

    assign bus.tick_end = w_end;
    assign bus.tick_mid = bus.clk_ena && (r_cnt == w_mid);

    generate
        if (MAJ3 != 0) begin : g_maj3
            assign bus.tick_pre  = bus.clk_ena && (r_cnt == w_mid - ONE);
            assign bus.tick_post = bus.clk_ena && (r_cnt == w_mid + ONE);
        end else begin : g_nomaj3
            assign bus.tick_pre  = 1'b0;
            assign bus.tick_post = 1'b0;
        end
    endgenerate
endmodule

// File: doc/baudgen_frac.md
Name: baudgen_frac

Overview:
- Programmable fractional baud-tick generator; next generation of the fixed-divisor receive baud generator.
- Divisor is runtime-loadable as integer plus fraction (clock cycles per bit). Fractional part is spread by a phase accumulator, so bit periods alternate between div_int and div_int+1 cycles.
- Emits bit-end and mid-bit strobes, plus optional pre/post-mid strobes for 3-sample majority voting.
- Sits between the UART rx/tx bit FSMs and the system clock; a host register block drives the cfg_* port.

Parameters:
- DIV_W, 16, width of integer divisor.
- FRAC_W, 4, width of fractional divisor (units of 1/2^FRAC_W cycle).
- MAJ3, 1, 1 enables tick_pre/tick_post; 0 ties them low.
- DEF_DIV_INT, 104, integer divisor after reset (12 MHz / 115200).
- DEF_DIV_FRAC, 3, fractional divisor after reset.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- clk_ena  in  1  run enable; low = idle, period realigned
- cfg_div_int  in  DIV_W  new integer divisor
- cfg_div_frac  in  FRAC_W  new fractional divisor
- cfg_load  in  1  one-cycle strobe, captures cfg_div_*
- cfg_pending  out  1  captured divisor not yet applied
- cfg_clamped  out  1  last applied div_int was below MIN_DIV and was clamped
- tick_pre  out  1  strobe at mid-1 (MAJ3 only)
- tick_mid  out  1  mid-bit sample strobe
- tick_post  out  1  strobe at mid+1 (MAJ3 only)
- tick_end  out  1  last cycle of bit period

Behaviour:
- One clock only: clk. Asynchronous active-low reset rstn.
- Reset values:
  - counter = 0, acc = 0, p_len = DEF_DIV_INT.
  - Active divisor = DEF_DIV_INT / DEF_DIV_FRAC.
  - cfg_pending = 0, cfg_clamped = 0, all ticks = 0.
- Clamping: MIN_DIV = 4 if MAJ3 else 2. Any applied div_int < MIN_DIV is replaced by MIN_DIV and sets cfg_clamped = 1. cfg_clamped holds until the next apply.
- Registered state:
  - counter, DIV_W+1 bits.
  - p_len, DIV_W+1 bits.
  - acc, FRAC_W bits.
  - Active divisor register.
  - Pending shadow register.
- Idle (clk_ena = 0):
  - counter <= 0, acc <= 0, p_len <= active div_int.
  - All ticks forced 0 (ticks are combinational and gated by clk_ena).
  - A pending divisor is applied on the next idle cycle; cfg_pending then falls.
- Run (clk_ena = 1): counter counts 0..p_len-1. The first enabled cycle is counter = 0.
  - mid = p_len >> 1.
  - tick_mid = (counter == mid).
  - tick_pre = (counter == mid-1).
  - tick_post = (counter == mid+1).
  - tick_end = (counter == p_len-1).
- Boundary (tick_end cycle):
  - Apply the pending divisor if any; this cycle's cfg_load is bypassed and applied here too.
  - {c, acc} <= acc + div_frac, using the newly applied div_frac.
  - p_len <= div_int + c, counter <= 0.
  - So the first period after enable is exactly div_int. Average period is div_int + div_frac/2^FRAC_W.
- cfg_load handling:
  - Captures inputs into the shadow and sets cfg_pending.
  - A second cfg_load before apply overwrites the shadow (last writer wins).
  - Divisor is never changed mid-period.
- clk_ena falling mid-period: ticks stop in that same cycle; the partial period is discarded; the next enable restarts at counter 0, acc 0.
- Reset mid-operation: immediate return to reset values; any pending load is lost.
- Arithmetic: all compares at DIV_W+1 bits; no wrap beyond p_len-1.

Decomposition:
- Shared include baudgen.vh: existing baud constants, plus new fractional pairs for the 12 MHz clock (e.g. B115200_INT 104 / B115200_FRAC 3, B9600_INT 1250 / B9600_FRAC 0), and MIN_DIV values.
- One natural sub-module: baudgen_cfg_shadow. It owns the shadow register, cfg_pending, the clamp and cfg_clamped, and outputs the active divisor on an apply strobe from the parent.

Test Plan:
- Reset, then clk_ena = 1 for 500 cycles with defaults -> first tick_end at cycle 103, tick_mid at cycle 52; periods 104,104,104,104,104,104,105 (acc reaches 16 on the 6th boundary).
- Load int = 10, frac = 8 while idle, then enable -> cfg_pending falls the cycle after load; periods 10,10,11,10,11; tick_mid at counter 5 in every period; MAJ3 gives tick_pre at 4 and tick_post at 6.
- Running at int = 10, load int = 20 at counter 3 -> current period still ends at cycle 9; next period is 20 (+carry); cfg_pending high from load until that tick_end.
- cfg_load coincident with tick_end -> new divisor used for the very next period; cfg_pending never asserts.
- Load int = 1 with MAJ3 = 1 -> applied as 4, cfg_clamped = 1; next valid load (int = 8) clears cfg_clamped.
- Drop clk_ena at counter 7 of a 10-cycle period, re-enable 3 cycles later -> no ticks while low; first tick_end exactly 10 cycles after re-enable; assert rstn low mid-period -> all outputs 0 asynchronously, divisor back to 104/3.
